count_checker: RTL and testbench
================================

// Module: count_checker
// PURPOSE
//   Synthesizable monitor on the consuming side of the free-running 4-bit counter.
//   Samples the counter output Q each clock and checks that successive values step by +1 mod 2^WIDTH,
//   or are 0 after the counter's own clear. Reports lock, per-sample mismatch, wrap and a saturating error count.
//   Sits beside the counter in the counter testbench and on-chip as a self-check.
// PARAMETERS
//   WIDTH      4  width of observed count Q
//   ERR_CNT_W  8  width of saturating mismatch counter
//   SYNC_LEN   2  consecutive good steps needed before lock (>=1)
// PORTS
//   clock      in   1          single clock, all logic on rising edge
//   clear      in   1          synchronous, active-high reset of this checker
//   q_in       in   WIDTH      observed counter value Q
//   q_valid    in   1          q_in is a live sample this cycle; low = counter paused
//   dut_clear  in   1          counter's clear, same cycle as q_in
//   locked     out  1          checker tracking (state TRACK)
//   mismatch   out  1          1-cycle pulse, checked sample was wrong
//   wrap       out  1          1-cycle pulse, legal step all-ones -> 0 seen
//   expected   out  WIDTH      value required at next valid sample
//   err_count  out  ERR_CNT_W  mismatches since clear, saturating
//   fail       out  1          sticky, set on first mismatch
// BEHAVIOUR
//   - Reset (clear=1 at edge): state IDLE; locked=0, mismatch=0, wrap=0, expected=0, err_count=0, fail=0, good_cnt=0.
//     clear dominates all other inputs; a clear mid-TRACK drops lock on the next edge.
//   - nxt = dut_clear ? 0 : (q_in+1) mod 2^WIDTH, evaluated on each valid sample; expected <= nxt.
//   - q_valid=0: no check, state/expected/good_cnt hold, pulses low.
//   - IDLE: first valid sample -> SYNC, expected<=nxt, good_cnt<=0; never a mismatch.
//   - SYNC: valid sample == expected -> good_cnt++; at good_cnt==SYNC_LEN-1 -> TRACK.
//     Sample != expected -> good_cnt<=0, stay SYNC, expected<=nxt; no mismatch, no err_count.
//   - TRACK: valid sample == expected -> stay; sample != expected -> mismatch=1 next cycle,
//     err_count++ (holds at 2^ERR_CNT_W-1), fail<=1, exit per CONFIGURATION.
//   - All outputs registered: mismatch/wrap/locked update at the edge after the sample (latency 1).
//   - wrap: in TRACK, when a correct sample equals 0 and previous sample was all-ones (not via dut_clear).
//   - dut_clear with q_valid: that sample checked normally; next required value is 0.
// CONFIGURATION
//   COUNT_CHECKER_RESYNC_EN defined: TRACK mismatch -> SYNC, good_cnt<=0, expected<=nxt; checker relocks
//     after SYNC_LEN good steps; fail remains sticky.
//   Not defined: TRACK mismatch -> FAIL (terminal until clear); locked=0, no further checks,
//     mismatch/wrap stay 0, err_count frozen, expected frozen.
// STRUCTURE
//   count_checker_pkg: state enum {IDLE,SYNC,TRACK,FAIL}, default WIDTH/ERR_CNT_W/SYNC_LEN constants.
//   Sub-module sat_counter (WIDTH, inc, clear -> value) used for err_count; FSM and compare inline.
// TESTING
//   1 Reset: clear=1 3 cycles with random q_in -> all outputs 0, state IDLE.
//   2 Lock: q_in 3,4,5,6 valid each cycle -> locked=1 one edge after sample 5 (SYNC_LEN=2), no mismatch.
//   3 Wrap: locked, q_in ...14,15,0,1 -> single wrap pulse the cycle after 0, mismatch stays 0.
//   4 Clear-of-counter: locked at 9 with dut_clear=1, next q_in 0 -> no mismatch; next q_in 10 instead -> mismatch, err_count=1, fail=1.
//   5 Pause: locked at 7, q_valid=0 for 5 cycles, then q_in 8 -> no mismatch; expected held at 8 throughout.
//   6 Fault: locked, q_in 4,6,7,8 -> mismatch one pulse; RESYNC_EN: relock after 7,8, err_count=1; else state FAIL, locked=0,
//     err_count stays 1; 300 forced mismatches with RESYNC_EN -> err_count=255.

Source files
------------

// File: rtl/count_checker_pkg.sv
// count_checker_pkg: shared constants for the counter self-check monitor.
// Holds the default geometry, the FSM state encodings and a width helper.
package count_checker_pkg;

    // Default geometry of the observed counter and the checker
    localparam int unsigned CC_WIDTH     = 4;
    localparam int unsigned CC_ERR_CNT_W = 8;
    localparam int unsigned CC_SYNC_LEN  = 2;

    // FSM state encodings
    localparam int unsigned ST_W = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    localparam logic [1:0] ST_FAIL  = 2'd3;

    // Bits needed to hold a count from 0 to n (never less than 1)
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : count_checker_pkg

// File: rtl/count_checker_sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-high clear.
// Counts one per cycle while inc is high and parks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             at_max_c;

    // Next value: increment unless already saturated
    always_comb begin
        value_d  = value_q;
        at_max_c = (value_q == {WIDTH{1'b1}});
        if (inc && !at_max_c) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clock) begin
        if (clear) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule : sat_counter

// File: rtl/count_checker.sv
// count_checker: consumer-side monitor for a free-running modulo counter.
// Locks after SYNC_LEN consecutive good steps, then flags every wrong sample.
// Build option COUNT_CHECKER_RESYNC_EN: a tracked mismatch drops back to
// resynchronisation instead of parking in the terminal FAIL state.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int unsigned WIDTH     = CC_WIDTH,
    parameter int unsigned ERR_CNT_W = CC_ERR_CNT_W,
    parameter int unsigned SYNC_LEN  = CC_SYNC_LEN
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     q_in,
    input  logic                 q_valid,
    input  logic                 dut_clear,
    output logic                 locked,
    output logic                 mismatch,
    output logic                 wrap,
    output logic [WIDTH-1:0]     expected,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 fail
);

    localparam int unsigned GOOD_W = cnt_width(SYNC_LEN);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(SYNC_LEN - 1);

    logic [ST_W-1:0]   state_q,     state_d;
    logic [WIDTH-1:0]  expected_q,  expected_d;
    logic [GOOD_W-1:0] good_q,      good_d;
    logic              prev_ones_q, prev_ones_d;
    logic              locked_q;
    logic              mismatch_q,  mismatch_d;
    logic              wrap_q,      wrap_d;
    logic              fail_q,      fail_d;

    logic [WIDTH-1:0]  nxt_c;
    logic              hit_c;

    // Value the counter must show at its next live sample
    assign nxt_c = dut_clear ? '0 : (q_in + WIDTH'(1));
    assign hit_c = (q_in == expected_q);

    // Next-state, compare and pulse generation
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        good_d      = good_q;
        prev_ones_d = prev_ones_q;
        mismatch_d  = 1'b0;
        wrap_d      = 1'b0;
        fail_d      = fail_q;

        if (q_valid) begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_SYNC;
                    expected_d  = nxt_c;
                    good_d      = '0;
                    prev_ones_d = (q_in == {WIDTH{1'b1}}) && !dut_clear;
                end
                ST_SYNC: begin
                    expected_d  = nxt_c;
                    prev_ones_d = (q_in == {WIDTH{1'b1}}) && !dut_clear;
                    if (hit_c) begin
                        if (good_q == GOOD_LAST) begin
                            state_d = ST_TRACK;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_TRACK: begin
                    if (hit_c) begin
                        expected_d  = nxt_c;
                        // A real rollover, not a counter clear that happened to follow all-ones
                        wrap_d      = (q_in == '0) && prev_ones_q;
                        prev_ones_d = (q_in == {WIDTH{1'b1}}) && !dut_clear;
                    end else begin
                        mismatch_d = 1'b1;
                        fail_d     = 1'b1;
`ifdef COUNT_CHECKER_RESYNC_EN
                        state_d     = ST_SYNC;
                        good_d      = '0;
                        expected_d  = nxt_c;
                        prev_ones_d = (q_in == {WIDTH{1'b1}}) && !dut_clear;
`else
                        state_d = ST_FAIL;
`endif
                    end
                end
                ST_FAIL: begin
                    // Terminal until clear: nothing is checked or updated
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers, synchronous clear
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            expected_q  <= '0;
            good_q      <= '0;
            prev_ones_q <= 1'b0;
            locked_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            wrap_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            good_q      <= good_d;
            prev_ones_q <= prev_ones_d;
            locked_q    <= (state_d == ST_TRACK);
            mismatch_q  <= mismatch_d;
            wrap_q      <= wrap_d;
            fail_q      <= fail_d;
        end
    end

    // Saturating tally of tracked mismatches
    sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clock (clock),
        .clear (clear),
        .inc   (mismatch_d),
        .value (err_count)
    );

    assign locked   = locked_q;
    assign mismatch = mismatch_q;
    assign wrap     = wrap_q;
    assign expected = expected_q;
    assign fail     = fail_q;

endmodule : count_checker

// File: tb/tb_count_checker.sv
// tb_count_checker: directed-vector bench for count_checker (WIDTH=4, ERR_CNT_W=8, SYNC_LEN=2).
// Honours COUNT_CHECKER_RESYNC_EN so the same bench covers both builds.
module tb_count_checker;

    logic       clock;
    logic       clear;
    logic [3:0] q_in;
    logic       q_valid;
    logic       dut_clear;
    logic       locked;
    logic       mismatch;
    logic       wrap;
    logic [3:0] expected;
    logic [7:0] err_count;
    logic       fail;

    int n_vec;
    int n_err;

    count_checker #(
        .WIDTH     (4),
        .ERR_CNT_W (8),
        .SYNC_LEN  (2)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .q_in      (q_in),
        .q_valid   (q_valid),
        .dut_clear (dut_clear),
        .locked    (locked),
        .mismatch  (mismatch),
        .wrap      (wrap),
        .expected  (expected),
        .err_count (err_count),
        .fail      (fail)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, want);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle past the rising edge
    task automatic drive(input logic clr, input logic vld, input logic [3:0] q, input logic dc);
        @(negedge clock);
        clear     = clr;
        q_valid   = vld;
        q_in      = q;
        dut_clear = dc;
        @(posedge clock);
        #1;
    endtask

    task automatic step(input int q);
        drive(1'b0, 1'b1, 4'(q), 1'b0);
    endtask

    initial begin
        int s;
        int e;
        n_vec     = 0;
        n_err     = 0;
        clear     = 1'b1;
        q_valid   = 1'b1;
        q_in      = '0;
        dut_clear = 1'b0;

        // Reset with live random samples: clear must dominate
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 4'($urandom), 1'($urandom));
        chk("rst_locked",   32'(locked),    0);
        chk("rst_mismatch", 32'(mismatch),  0);
        chk("rst_wrap",     32'(wrap),      0);
        chk("rst_expected", 32'(expected),  0);
        chk("rst_err",      32'(err_count), 0);
        chk("rst_fail",     32'(fail),      0);

        // Lock on 3,4,5,6
        step(3);
        chk("lock3_locked",   32'(locked),   0);
        chk("lock3_expected", 32'(expected), 4);
        chk("lock3_mismatch", 32'(mismatch), 0);
        step(4);
        chk("lock4_locked",   32'(locked),   0);
        step(5);
        chk("lock5_locked",   32'(locked),   1);
        chk("lock5_mismatch", 32'(mismatch), 0);
        step(6);
        chk("lock6_locked",   32'(locked),   1);
        chk("lock6_expected", 32'(expected), 7);

        // Wrap 14,15,0,1
        for (int v = 7; v <= 13; v++) begin
            step(v);
            chk("run_mismatch", 32'(mismatch), 0);
        end
        step(14);
        chk("wrap14", 32'(wrap), 0);
        step(15);
        chk("wrap15",     32'(wrap),     0);
        chk("wrap15_exp", 32'(expected), 0);
        step(0);
        chk("wrap0",          32'(wrap),     1);
        chk("wrap0_mismatch", 32'(mismatch), 0);
        step(1);
        chk("wrap1", 32'(wrap), 0);

        // Counter clear at 9, then a legal 0
        for (int v = 2; v <= 8; v++) step(v);
        drive(1'b0, 1'b1, 4'd9, 1'b1);
        chk("dclr9_expected", 32'(expected), 0);
        chk("dclr9_mismatch", 32'(mismatch), 0);
        step(0);
        chk("dclr0_mismatch", 32'(mismatch), 0);
        chk("dclr0_wrap",     32'(wrap),     0);
        chk("dclr0_locked",   32'(locked),   1);
        chk("dclr0_expected", 32'(expected), 1);

        // Counter clear at 9, then an illegal 10
        for (int v = 1; v <= 8; v++) step(v);
        drive(1'b0, 1'b1, 4'd9, 1'b1);
        step(10);
        chk("dclr10_mismatch", 32'(mismatch),  1);
        chk("dclr10_err",      32'(err_count), 1);
        chk("dclr10_fail",     32'(fail),      1);
        chk("dclr10_locked",   32'(locked),    0);
`ifdef COUNT_CHECKER_RESYNC_EN
        chk("dclr10_expected", 32'(expected), 11);
`else
        chk("dclr10_expected", 32'(expected), 0);
`endif
        step(11);
        chk("dclr11_mismatch", 32'(mismatch),  0);
        chk("dclr11_err",      32'(err_count), 1);

        drive(1'b1, 1'b1, 4'($urandom), 1'b0);
        chk("clr2_err",      32'(err_count), 0);
        chk("clr2_fail",     32'(fail),      0);
        chk("clr2_locked",   32'(locked),    0);
        chk("clr2_expected", 32'(expected),  0);

        // A wrong sample during SYNC only restarts the good-step run
        step(3);
        step(9);
        chk("sync9_mismatch", 32'(mismatch),  0);
        chk("sync9_err",      32'(err_count), 0);
        chk("sync9_expected", 32'(expected),  10);
        step(10);
        chk("sync10_locked", 32'(locked), 0);
        step(11);
        chk("sync11_locked", 32'(locked), 1);

        // Pause at 7 for 5 cycles, then 8
        for (int i = 0; i < 12; i++) step((12 + i) % 16);
        chk("pause_pre_exp", 32'(expected), 8);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 4'($urandom), 1'($urandom));
            chk("pause_expected", 32'(expected), 8);
            chk("pause_mismatch", 32'(mismatch), 0);
            chk("pause_locked",   32'(locked),   1);
        end
        step(8);
        chk("pause8_mismatch", 32'(mismatch), 0);
        chk("pause8_expected", 32'(expected), 9);

        // Fault: 4,6,7,8
        for (int v = 9; v <= 19; v++) step(v % 16);
        step(4);
        chk("flt4_expected", 32'(expected), 5);
        step(6);
        chk("flt6_mismatch", 32'(mismatch),  1);
        chk("flt6_err",      32'(err_count), 1);
        chk("flt6_fail",     32'(fail),      1);
        chk("flt6_locked",   32'(locked),    0);
        step(7);
        chk("flt7_mismatch", 32'(mismatch), 0);
        chk("flt7_locked",   32'(locked),   0);
`ifdef COUNT_CHECKER_RESYNC_EN
        chk("flt7_expected", 32'(expected), 8);
        step(8);
        chk("flt8_locked", 32'(locked),    1);
        chk("flt8_err",    32'(err_count), 1);
        chk("flt8_fail",   32'(fail),      1);

        // Drive the error tally into saturation
        e = 9;
        for (int i = 0; i < 300; i++) begin
            s = (e + 1) % 16;
            step(s);
            if (i == 0) begin
                chk("sat_first_mismatch", 32'(mismatch),  1);
                chk("sat_first_err",      32'(err_count), 2);
            end
            step((s + 1) % 16);
            step((s + 2) % 16);
            e = (s + 3) % 16;
            if (i == 99) chk("sat_mid_err", 32'(err_count), 101);
        end
        chk("sat_err",      32'(err_count), 255);
        chk("sat_locked",   32'(locked),    1);
        chk("sat_mismatch", 32'(mismatch),  0);
`else
        chk("flt7_expected", 32'(expected), 5);
        step(8);
        chk("flt8_locked",   32'(locked),    0);
        chk("flt8_err",      32'(err_count), 1);
        chk("flt8_mismatch", 32'(mismatch),  0);
        chk("flt8_expected", 32'(expected),  5);
        step(2);
        chk("fail_nocheck_mismatch", 32'(mismatch),  0);
        chk("fail_nocheck_err",      32'(err_count), 1);
`endif

        // Clear mid-TRACK drops lock on the next edge
        drive(1'b1, 1'b1, 4'($urandom), 1'b0);
        step(3);
        step(4);
        step(5);
        chk("relock_locked", 32'(locked), 1);
        drive(1'b1, 1'b1, 4'd6, 1'b0);
        chk("midclr_locked",   32'(locked),    0);
        chk("midclr_expected", 32'(expected),  0);
        chk("midclr_err",      32'(err_count), 0);
        chk("midclr_fail",     32'(fail),      0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_count_checker
